// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC generator, icache request port and 2-entry fetch queue
// feeding decode. Redirects flush the queue; a fetched HALT word stops fetching.
//
// Handshakes:
//   icache: a read is requested while imemREN is high; imemaddr (== pc) holds
//           until ihit, and iload is accepted in the cycle ihit && imemREN.
//   decode: the head entry is offered while instr_valid is high and leaves the
//           queue at the rising edge where instr_valid && dec_ready (unless a
//           redirect is present in that cycle).
module instr_fetch_unit #(
  parameter logic [31:0] PC0   = 32'h0000_0000,
  parameter int          DEPTH = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] iload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        dec_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        halted
);

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t      state_q;
  logic        halted_q;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr;
  logic [31:0] word_q [DEPTH];
  logic [31:0] epc_q  [DEPTH];
  logic        push, pop, is_halt;

  // Request only while fetching with a free slot; a redirect cancels this
  // cycle's request because pc is about to be replaced.
  assign imemREN  = nRST && (state_q == FETCH) && (count_q < 2'(DEPTH)) && !redirect;
  assign imemaddr = pc_q;

  assign push    = imemREN && ihit;
  assign pop     = instr_valid && dec_ready && !redirect;
  assign is_halt = (iload[31:26] == 6'b111111);

  // Tail slot sits count entries past the head (modulo 2).
  assign wr_ptr = rd_ptr_q ^ count_q[0];

  assign instr_valid = (count_q != 2'd0);
  assign instruction = instr_valid ? word_q[rd_ptr_q] : 32'h0;
  assign instr_pc    = instr_valid ? epc_q[rd_ptr_q]  : 32'h0;
  assign halted      = halted_q;

  // Next pc, occupancy and head pointer; redirect overrides push and pop.
  always_comb begin
    pc_d     = pc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    if (redirect) begin
      pc_d     = redirect_pc & ~32'h3;
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push) pc_d = pc_q + 32'd4;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      if (pop) rd_ptr_d = ~rd_ptr_q;
    end
  end

  // Datapath registers: pc, queue pointers and queue storage.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pc_q     <= PC0;
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        word_q[i] <= 32'h0;
        epc_q[i]  <= 32'h0;
      end
    end else begin
      pc_q     <= pc_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      if (push) begin
        word_q[wr_ptr] <= iload;
        epc_q[wr_ptr]  <= pc_q;
      end
    end
  end

  // Fetch FSM: a pushed HALT word parks the unit until the next redirect.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= FETCH;
      halted_q <= 1'b0;
    end else if (redirect) begin
      state_q  <= FETCH;
      halted_q <= 1'b0;
    end else if (state_q == FETCH && push && is_halt) begin
      state_q  <= HALTED;
      halted_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: directed scenarios plus random traffic,
// checked against a queue-based reference model.
module tb_instr_fetch_unit;

  localparam logic [31:0] PC0 = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        ihit = 1'b0;
  logic [31:0] iload = 32'h0;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        dec_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        halted;

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  instr_fetch_unit #(.PC0(PC0), .DEPTH(2)) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .ihit        (ihit),
    .iload       (iload),
    .imemREN     (imemREN),
    .imemaddr    (imemaddr),
    .instruction (instruction),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .dec_ready   (dec_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halted      (halted)
  );

  // ---------------- reference model state ----------------
  // exp_q holds {word, pc} of every entry the unit should currently buffer.
  logic [63:0] exp_q[$];
  logic [31:0] m_pc = PC0;
  logic        m_halted = 1'b0;
  logic        rst_n_next = 1'b0;
  int          checks = 0;
  int          failures = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- driver ----------------
  // One clock cycle of stimulus; the model absorbs the edge just after it.
  task automatic cycle(input logic hit, input logic [31:0] word, input logic dr,
                       input logic rd, input logic [31:0] rpc);
    logic ren, push;
    @(negedge CLK);
    nRST        = rst_n_next;
    ihit        = hit;
    iload       = word;
    dec_ready   = dr;
    redirect    = rd;
    redirect_pc = rpc;
    ren  = nRST && !m_halted && (exp_q.size() < 2) && !rd;
    push = ren && hit;
    @(posedge CLK);
    #1;
    if (!nRST) begin
      exp_q.delete();
      m_pc = PC0;
      m_halted = 1'b0;
    end else if (rd) begin
      exp_q.delete();
      m_pc = {rpc[31:2], 2'b00};
      m_halted = 1'b0;
    end else if (push) begin
      exp_q.push_back({word, m_pc});
      m_pc = m_pc + 32'd4;
      if (word[31:26] == 6'b111111) m_halted = 1'b1;
    end
  endtask

  // Pull reset between edges and confirm outputs clear without a clock.
  task automatic async_reset_check();
    @(negedge CLK);
    #3;
    nRST = 1'b0;
    rst_n_next = 1'b0;
    #1;
    chk("async_valid", instr_valid, 0);
    chk("async_ren", imemREN, 0);
    chk("async_addr", imemaddr, PC0);
    chk("async_instr", instruction, 0);
    chk("async_ipc", instr_pc, 0);
    chk("async_halted", halted, 0);
    exp_q.delete();
    m_pc = PC0;
    m_halted = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  // Compares outputs each cycle after inputs settle; pops the expected head
  // when decode takes it.
  always begin
    logic exp_ren;
    @(negedge CLK);
    #2;
    exp_ren = nRST && !m_halted && (exp_q.size() < 2) && !redirect;
    chk("imemREN", imemREN, exp_ren);
    chk("imemaddr", imemaddr, m_pc);
    chk("halted", halted, m_halted);
    chk("instr_valid", instr_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      chk("instruction", instruction, exp_q[0][63:32]);
      chk("instr_pc", instr_pc, exp_q[0][31:0]);
      if (dec_ready && !redirect && nRST) void'(exp_q.pop_front());
    end else begin
      chk("instruction_empty", instruction, 0);
      chk("instr_pc_empty", instr_pc, 0);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] w;
    // Reset held for two cycles.
    rst_n_next = 1'b0;
    repeat (2) cycle(1'b1, 32'h0, 1'b1, 1'b0, 32'h0);
    rst_n_next = 1'b1;

    // Stream: one word per cycle from PC0.
    for (int k = 0; k < 8; k++)
      cycle(1'b1, 32'h2001_0001 + 32'h0001_0001 * k, 1'b1, 1'b0, 32'h0);

    // Backpressure: decode stalls, queue fills, fetch stops, then drains.
    cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
    for (int k = 0; k < 4; k++)
      cycle(1'b1, 32'h3000_0000 + k, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 4; k++)
      cycle(1'b1, 32'h3100_0000 + k, 1'b1, 1'b0, 32'h0);

    // Cache miss at 0x40: address must hold while ihit is low.
    cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'h40);
    repeat (5) cycle(1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 32'h2222_0040, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

    // Redirect with a full queue and a same-cycle hit that must vanish.
    for (int k = 0; k < 3; k++)
      cycle(1'b1, 32'h4000_0000 + k, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 32'hBAD0_BAD0, 1'b1, 1'b1, 32'h103);
    for (int k = 0; k < 3; k++)
      cycle(1'b1, 32'h5000_0000 + k, 1'b1, 1'b0, 32'h0);

    // HALT at 0x10: queued words plus HALT drain, no further requests.
    cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'h8);
    cycle(1'b1, 32'h6000_0008, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 32'h6000_000C, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 32'h7777_7777, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 32'hFC00_0000, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 5; k++)
      cycle(1'b1, 32'h0123_4567, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'h200);
    for (int k = 0; k < 3; k++)
      cycle(1'b1, 32'h6100_0000 + k, 1'b1, 1'b0, 32'h0);

    // PC wrap: 0xFFFF_FFFC is followed by 0.
    cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    for (int k = 0; k < 3; k++)
      cycle(1'b1, 32'h7000_0000 + k, 1'b1, 1'b0, 32'h0);

    // Async reset mid-stream with hits in flight.
    cycle(1'b1, 32'h7100_0000, 1'b0, 1'b0, 32'h0);
    async_reset_check();
    cycle(1'b1, 32'h7200_0000, 1'b1, 1'b0, 32'h0);
    rst_n_next = 1'b1;
    for (int k = 0; k < 3; k++)
      cycle(1'b1, 32'h7300_0000 + k, 1'b1, 1'b0, 32'h0);

    // Random traffic.
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        async_reset_check();
        cycle(1'(($urandom_range(0, 1))), $urandom(), 1'b1, 1'b0, 32'h0);
        rst_n_next = 1'b1;
      end
      w = $urandom();
      if ($urandom_range(0, 19) == 0) w[31:26] = 6'b111111;
      cycle($urandom_range(0, 9) < 7, w, $urandom_range(0, 9) < 7,
            $urandom_range(0, 19) == 0, $urandom());
    end

    cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    @(negedge CLK);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
